// File: rtl/dso_pkg.sv
// Shared types and constants for the scope's trace capture and readout path.
package dso_pkg;

  localparam int TRACE_DEPTH = 512;
  localparam int NUM_CH      = 3;
  localparam logic [1:0] CH_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAT,
    ST_SEND,
    ST_TXW,
    ST_FIN
  } dump_state_t;

endpackage

// File: rtl/dump_addr_gen.sv
// Circular read-address walker for trace readout: wrapping address plus sample count.
module dump_addr_gen
  import dso_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int AW    = 9,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] start_addr,
  input  logic          inc,
  output logic [AW-1:0] rd_addr,
  output logic          last
);

  logic [CW-1:0] smpl_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr  <= '0;
      smpl_cnt <= '0;
    end else if (load) begin
      rd_addr  <= start_addr;
      smpl_cnt <= '0;
    end else if (inc) begin
      // DEPTH is a power of two, so natural AW-bit overflow is the wrap.
      rd_addr  <= rd_addr + AW'(1);
      smpl_cnt <= smpl_cnt + CW'(1);
    end
  end

  assign last = (smpl_cnt == CW'(DEPTH));

endmodule

// File: rtl/trace_dump_ctrl.sv
// Reads one channel's circular trace buffer oldest-to-newest and streams it to the UART.
module trace_dump_ctrl
  import dso_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int AW    = 9,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_done,
  input  logic [AW-1:0] trace_end,
  input  logic          dump_req,
  input  logic [1:0]    dump_ch,
  input  logic          dump_abort,
  output logic [2:0]    ram_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] tx_data,
  output logic          trmt,
  input  logic          tx_done,
  output logic          dump_busy,
  output logic          dump_done,
  output logic          dump_err,
  output logic          clr_capture_done
);

  dump_state_t state, state_n;
  logic [1:0]  ch_q;
  logic        load, inc, last, req_ok, err_n;

  assign req_ok = capture_done && (dump_ch != CH_INVALID);

  dump_addr_gen #(.DEPTH(DEPTH), .AW(AW)) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .start_addr (trace_end + AW'(1)),
    .inc        (inc),
    .rd_addr    (rd_addr),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ch_q     <= '0;
      tx_data  <= '0;
      dump_err <= 1'b0;
    end else begin
      state    <= state_n;
      dump_err <= err_n;
      if (load) ch_q <= dump_ch;
      if (state == ST_LAT) tx_data <= rd_data;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n          = state;
    ram_en           = '0;
    trmt             = 1'b0;
    dump_done        = 1'b0;
    clr_capture_done = 1'b0;
    load             = 1'b0;
    inc              = 1'b0;
    err_n            = 1'b0;

    case (state)
      ST_IDLE: begin
        if (dump_req) begin
          if (req_ok) begin
            load    = 1'b1;
            state_n = ST_RD;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_RD: begin
        ram_en  = 3'b001 << ch_q;
        state_n = ST_LAT;
      end
      ST_LAT:  state_n = ST_SEND;
      ST_SEND: begin
        trmt    = 1'b1;
        inc     = 1'b1;
        state_n = ST_TXW;
      end
      ST_TXW: begin
        if (tx_done) state_n = last ? ST_FIN : ST_RD;
      end
      ST_FIN: begin
        dump_done        = 1'b1;
        clr_capture_done = 1'b1;
        state_n          = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // Abort outranks everything in the same cycle, including this cycle's strobes.
    if (dump_abort && (state != ST_IDLE)) begin
      state_n          = ST_IDLE;
      ram_en           = '0;
      trmt             = 1'b0;
      dump_done        = 1'b0;
      clr_capture_done = 1'b0;
      inc              = 1'b0;
    end
  end

  assign dump_busy = (state != ST_IDLE);

endmodule
